// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key_debounce channels: FSM state encoding and counter sizing.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Bits needed to hold values 0..n-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, bounce-filter FSM and optional auto-repeat.
// The auto-repeat hold counter exists only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int unsigned      CNT_W    = clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic             synced;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign synced = sync[1];

    // Synchroniser resets to released so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync        <= 2'b00;
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync        <= {sync[0], key_in};
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                RELEASED: begin
                    if (synced) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!synced) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!synced) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (synced) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RELEASED;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                       REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned       HOLD_W     = clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_RATE_CYC - 1);

    logic [HOLD_W-1:0] hold;
    logic              armed;

    // First repeat after the initial delay, then one every rate period while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            armed      <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= 1'b0;
            if (state != PRESSED) begin
                hold  <= '0;
                armed <= 1'b0;
            end else if (hold == (armed ? HOLD_NEXT : HOLD_FIRST)) begin
                hold       <= '0;
                armed      <= 1'b1;
                key_repeat <= 1'b1;
            end else begin
                hold <= hold + HOLD_W'(1);
            end
        end
    end
`else
    // Repeat timing is accepted but has nothing to drive without the hold counter.
    if (REPEAT_DELAY_CYC == 0 || REPEAT_RATE_CYC == 0) begin : g_repeat_cfg_unused
    end

    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: polarity normalisation plus one debounce channel per key.
// Optional auto-repeat pulses are enabled by defining KEY_REPEAT_EN.
module key_debounce #(
    parameter int unsigned NUM_KEYS         = 4,
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter bit          ACTIVE_LOW       = 1'b1,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    logic [NUM_KEYS-1:0] pressed;

    // From here on 1 always means pressed.
    assign pressed = ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_in      (pressed[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length reference model plus directed scenarios.
module tb_key_debounce;

    localparam int NK    = 4;
    localparam int D     = 8;
    localparam int DELAY = 20;
    localparam int RATE  = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;

    int n_checks = 0;
    int n_pass   = 0;
    int press0_cnt = 0;
    int rep2_cnt   = 0;

    key_debounce #(
        .NUM_KEYS         (NK),
        .DEBOUNCE_CYC     (D),
        .ACTIVE_LOW       (1'b1),
        .REPEAT_DELAY_CYC (DELAY),
        .REPEAT_RATE_CYC  (RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    // Reference: a change is accepted once the pin (seen two edges late) has differed
    // from the accepted level on D+1 consecutive edges; repeats count edges held stable.
    logic [1:0]    m_hist  [NK];
    int            m_run   [NK];
    int            m_since [NK];
    logic [NK-1:0] m_level, m_press, m_release, m_repeat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NK; i++) begin
                m_hist[i]  = 2'b00;
                m_run[i]   = 0;
                m_since[i] = 0;
            end
            m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                logic s;
                s = m_hist[i][1];
                m_press[i] = 1'b0; m_release[i] = 1'b0; m_repeat[i] = 1'b0;
                if (m_level[i] && m_run[i] == 0) begin
                    m_since[i] = m_since[i] + 1;
                    if (REP_EN && m_since[i] >= DELAY && (m_since[i] - DELAY) % RATE == 0)
                        m_repeat[i] = 1'b1;
                end else begin
                    m_since[i] = 0;
                end
                if (s != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D + 1) begin
                        m_level[i]   = s;
                        m_press[i]   = s;
                        m_release[i] = ~s;
                        m_run[i]     = 0;
                        m_since[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_hist[i] = {m_hist[i][0], ~key_raw[i]};
            end
        end
    end

    task automatic check(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle comparison against the model, plus pulse tallies for the directed checks.
    always @(negedge clk) begin
        check("model_level",   key_level,   m_level);
        check("model_press",   key_press,   m_press);
        check("model_release", key_release, m_release);
        check("model_repeat",  key_repeat,  m_repeat);
        check("press_release_exclusive", key_press & key_release, '0);
        if (key_press[0])  press0_cnt++;
        if (key_repeat[2]) rep2_cnt++;
    end

    int base;

    initial begin
        rst = 1'b1;
        key_raw = 4'hF;
        tick(3);
        check("reset_level", key_level, 4'b0000);
        check("reset_press", key_press, 4'b0000);
        rst = 1'b0;
        tick(12);
        check("idle_level", key_level, 4'b0000);

        // 1: press key 0, pulse at edge 10
        key_raw[0] = 1'b0;
        tick(10);
        check("t1_press_edge9", key_press, 4'b0000);
        tick(1);
        check("t1_press_edge10", key_press, 4'b0001);
        check("t1_level", key_level, 4'b0001);
        tick(1);
        check("t1_press_edge11", key_press, 4'b0000);
        check("t1_level_held", key_level, 4'b0001);

        // 3: release key 0
        key_raw[0] = 1'b1;
        tick(10);
        check("t3_release_edge9", key_release, 4'b0000);
        tick(1);
        check("t3_release_edge10", key_release, 4'b0001);
        check("t3_level", key_level, 4'b0000);
        tick(1);
        check("t3_release_edge11", key_release, 4'b0000);
        tick(10);

        // 2: bounce every 3 cycles, then settle pressed
        base = press0_cnt;
        for (int i = 0; i < 10; i++) begin
            key_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        tick(8);
        check_int("t2_no_press_in_bounce", press0_cnt - base, 0);
        check("t2_level_in_bounce", key_level, 4'b0000);
        key_raw[0] = 1'b0;
        tick(11);
        check("t2_press_settled", key_press, 4'b0001);
        tick(3);
        check_int("t2_single_press", press0_cnt - base, 1);
        key_raw[0] = 1'b1;
        tick(14);

        // 4: keys 0 and 3 together
        key_raw = 4'b0110;
        tick(11);
        check("t4_press_pair", key_press, 4'b1001);
        check("t4_level_pair", key_level, 4'b1001);
        tick(1);
        check("t4_press_clear", key_press, 4'b0000);
        key_raw = 4'b1111;
        tick(14);

        // 5: reset while key 1 is held
        key_raw[1] = 1'b0;
        tick(11);
        check("t5_level_before_rst", key_level, 4'b0010);
        tick(3);
        #1 rst = 1'b1;
        #1;
        check("t5_level_async_clear", key_level, 4'b0000);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("t5_press_edge9", key_press, 4'b0000);
        tick(1);
        check("t5_press_after_rst", key_press, 4'b0010);
        key_raw[1] = 1'b1;
        tick(14);

        // 6: hold key 2 for 40 cycles
        key_raw[2] = 1'b0;
        tick(11);
        check("t6_press", key_press, 4'b0100);
        base = rep2_cnt;
        tick(19);
        check("t6_repeat_19", key_repeat, 4'b0000);
        tick(1);
        check("t6_repeat_20", key_repeat, REP_EN ? 4'b0100 : 4'b0000);
        tick(5);
        check("t6_repeat_25", key_repeat, REP_EN ? 4'b0100 : 4'b0000);
        tick(13);
        check_int("t6_repeat_count", rep2_cnt - base, REP_EN ? 4 : 0);
        key_raw[2] = 1'b1;
        tick(14);
        check("final_level", key_level, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
